// File: rtl/instr_mem_pkg.sv
// Shared types and defaults for the streaming-load instruction memory.
package instr_mem_pkg;

   localparam int unsigned DefDataW = 16;
   localparam int unsigned DefDepth = 400;
   localparam int unsigned DefAddrW = 9;

   localparam logic [DefDataW-1:0] NopWord = 16'h0000;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StReady
   } state_e;

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one synchronous read port, no reset.
module instr_mem_array
   import instr_mem_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned DEPTH  = DefDepth,
   parameter int unsigned ADDR_W = DefAddrW
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/instr_mem_stream.sv
// Instruction memory filled through a valid/ready load stream and read through a
// range-checked fetch port with one cycle of latency.
module instr_mem_stream
   import instr_mem_pkg::*;
#(
   parameter int unsigned        DATA_W   = DefDataW,
   parameter int unsigned        DEPTH    = DefDepth,
   parameter int unsigned        ADDR_W   = DefAddrW,
   parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(NopWord)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              load_done,
   output logic [ADDR_W:0]   load_count,
   output logic              overflow,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_err
);

   localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

   state_e            state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              wr_en;
   logic              fetch_hit;
   logic              valid_q, err_q, data_ok_q;
   logic [DATA_W-1:0] rd_data;

   // Hit uses the pre-edge count, so a fetch alongside load_start sees the old program.
   assign fetch_hit = (state_q == StReady) && ({1'b0, fetch_addr} < count_q);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      wr_en   = 1'b0;
      if (load_start) begin
         state_d = StLoad;
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (state_q == StLoad && load_valid) begin
         if (count_q < DepthCnt) begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
         if (load_last) begin
            state_d = StReady;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         data_ok_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         valid_q <= fetch_req;
         err_q   <= fetch_req && !fetch_hit;
         if (fetch_req) begin
            data_ok_q <= fetch_hit;
         end
      end
   end

   // Reads are only enabled on a hit, so unloaded or out-of-range words never reach the port.
   instr_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (count_q[ADDR_W-1:0]),
      .wr_data (load_data),
      .rd_en   (fetch_req && fetch_hit),
      .rd_addr (fetch_addr),
      .rd_data (rd_data)
   );

   assign load_ready  = (state_q == StLoad);
   assign load_done   = (state_q == StReady);
   assign load_count  = count_q;
   assign overflow    = ovf_q;
   assign fetch_valid = valid_q;
   assign fetch_err   = err_q;
   assign fetch_data  = data_ok_q ? rd_data : NOP_WORD;

endmodule
